// File: rtl/stall_ctrl.sv
// Pipeline interlock: detects operand hazards and HI/LO busy conflicts, stalls the
// front end, tracks the mult/div busy window and counts stall cycles since reset.
module stall_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  IDRs,
  input  logic [4:0]  IDRt,
  input  logic        IDUseRs,
  input  logic        IDUseRt,
  input  logic [1:0]  IDTuseRs,
  input  logic [1:0]  IDTuseRt,
  input  logic        IDIsMD,
  input  logic [4:0]  EXRegDst,
  input  logic [4:0]  MEMRegDst,
  input  logic [1:0]  EXTnew,
  input  logic [1:0]  MEMTnew,
  input  logic        EXStart,
  input  logic        EXIsDiv,
  input  logic        Req,
  output logic        Stall,
  output logic        PCEn,
  output logic        IFIDEn,
  output logic        IDEXClr,
  output logic        MDBusy,
  output logic [31:0] StallCnt
);

  localparam logic [3:0] MultLd = 4'(MULT_CYC);
  localparam logic [3:0] DivLd  = 4'(DIV_CYC);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        rs_haz, rt_haz, md_haz;

  // A source is hazardous when its producer is not forwardable before the
  // consumer needs it; $0 is hardwired and never waits on anything.
  always_comb begin
    rs_haz = IDUseRs && (IDRs != 5'd0) &&
             (((IDRs == EXRegDst) && (EXTnew > IDTuseRs)) ||
              ((IDRs == MEMRegDst) && (MEMTnew > IDTuseRs)));
    rt_haz = IDUseRt && (IDRt != 5'd0) &&
             (((IDRt == EXRegDst) && (EXTnew > IDTuseRt)) ||
              ((IDRt == MEMRegDst) && (MEMTnew > IDTuseRt)));
    md_haz = IDIsMD && (EXStart || MDBusy);
  end

  always_comb begin
    MDBusy   = (count_q != 4'd0);
    Stall    = (rs_haz || rt_haz || md_haz) && !Req;
    PCEn     = !Stall;
    IFIDEn   = !Stall;
    IDEXClr  = Stall || Req;
    StallCnt = stall_cnt_q;
  end

  // A start that coincides with a flush is squashed; a start while busy is ignored.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (EXStart && !Req) begin
          count_d = EXIsDiv ? DivLd : MultLd;
          state_d = (count_d != 4'd0) ? StBusy : StIdle;
        end
      end
      StBusy: begin
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        count_d = 4'd0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (Stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      count_q     <= 4'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_stall_ctrl.sv
// Randomized and directed bench for stall_ctrl against a cycle-indexed reference model.
module tb_stall_ctrl;

  localparam int unsigned MULT_CYC = 5;
  localparam int unsigned DIV_CYC  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  IDRs, IDRt, EXRegDst, MEMRegDst;
  logic        IDUseRs, IDUseRt, IDIsMD, EXStart, EXIsDiv, Req;
  logic [1:0]  IDTuseRs, IDTuseRt, EXTnew, MEMTnew;
  logic        Stall, PCEn, IFIDEn, IDEXClr, MDBusy;
  logic [31:0] StallCnt;

  int checks = 0;
  int errors = 0;

  // Model: MDBusy holds on every cycle index up to busy_last.
  longint cyc = 0;
  longint busy_last = -1;
  logic [31:0] m_cnt = 32'd0;

  stall_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk(clk), .reset(reset),
    .IDRs(IDRs), .IDRt(IDRt), .IDUseRs(IDUseRs), .IDUseRt(IDUseRt),
    .IDTuseRs(IDTuseRs), .IDTuseRt(IDTuseRt), .IDIsMD(IDIsMD),
    .EXRegDst(EXRegDst), .MEMRegDst(MEMRegDst), .EXTnew(EXTnew), .MEMTnew(MEMTnew),
    .EXStart(EXStart), .EXIsDiv(EXIsDiv), .Req(Req),
    .Stall(Stall), .PCEn(PCEn), .IFIDEn(IFIDEn), .IDEXClr(IDEXClr),
    .MDBusy(MDBusy), .StallCnt(StallCnt)
  );

  always #5 clk = ~clk;

  function automatic bit m_busy();
    return cyc <= busy_last;
  endfunction

  // Operand needed before its producer can forward it -> wait.
  function automatic bit src_wait(logic use_it, logic [4:0] r, logic [1:0] tuse);
    if (!use_it || r == 5'd0) return 1'b0;
    if (r == EXRegDst && int'(EXTnew) > int'(tuse)) return 1'b1;
    if (r == MEMRegDst && int'(MEMTnew) > int'(tuse)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_stall();
    bit haz;
    haz = src_wait(IDUseRs, IDRs, IDTuseRs) || src_wait(IDUseRt, IDRt, IDTuseRt) ||
          (IDIsMD && (EXStart || m_busy()));
    return haz && !Req;
  endfunction

  task automatic clear_inputs();
    reset = 1'b0; IDRs = '0; IDRt = '0; IDUseRs = 1'b0; IDUseRt = 1'b0;
    IDTuseRs = '0; IDTuseRt = '0; IDIsMD = 1'b0; EXRegDst = '0; MEMRegDst = '0;
    EXTnew = '0; MEMTnew = '0; EXStart = 1'b0; EXIsDiv = 1'b0; Req = 1'b0;
  endtask

  // Advance one clock, updating the model with the inputs held across the edge.
  task automatic tick();
    bit st;
    st = exp_stall();
    @(posedge clk);
    if (reset) begin
      busy_last = cyc;
      m_cnt = 32'd0;
    end else begin
      if (!m_busy() && EXStart && !Req)
        busy_last = cyc + longint'(EXIsDiv ? DIV_CYC : MULT_CYC);
      if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    #1;
    checks++;
    if (Stall !== 1'b0 || PCEn !== 1'b1 || IFIDEn !== 1'b1 || IDEXClr !== 1'b0) begin
      errors++;
      $display("FAIL reset_comb: got stall=%b pcen=%b ifiden=%b idexclr=%b want 0 1 1 0",
               Stall, PCEn, IFIDEn, IDEXClr);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (MDBusy !== 1'b0 || StallCnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: got mdbusy=%b stallcnt=%0d want 0 0", MDBusy, StallCnt);
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    EXRegDst = 5'd8; EXTnew = 2'd2; IDRs = 5'd8; IDUseRs = 1'b1; IDTuseRs = 2'd1;
    #1;
    checks++;
    if (Stall !== 1'b1 || IDEXClr !== 1'b1 || PCEn !== 1'b0) begin
      errors++;
      $display("FAIL load_use: got stall=%b idexclr=%b pcen=%b want 1 1 0",
               Stall, IDEXClr, PCEn);
    end
    EXTnew = 2'd1;
    #1;
    checks++;
    if (Stall !== 1'b0) begin
      errors++;
      $display("FAIL load_use_fwd: got stall=%b want 0", Stall);
    end
    clear_inputs();
    MEMRegDst = 5'd9; MEMTnew = 2'd1; IDRt = 5'd9; IDUseRt = 1'b1; IDTuseRt = 2'd0;
    #1;
    checks++;
    if (Stall !== 1'b1) begin
      errors++;
      $display("FAIL mem_rt_hazard: got stall=%b want 1", Stall);
    end
  endtask

  task automatic test_zero_filter();
    clear_inputs();
    EXRegDst = 5'd0; IDRs = 5'd0; IDUseRs = 1'b1; EXTnew = 2'd2; IDTuseRs = 2'd0;
    IDRt = 5'd0; IDUseRt = 1'b1; MEMRegDst = 5'd0; MEMTnew = 2'd2;
    #1;
    checks++;
    if (Stall !== 1'b0) begin
      errors++;
      $display("FAIL zero_filter: got stall=%b want 0", Stall);
    end
  endtask

  task automatic test_divide();
    int bad;
    apply_reset();
    IDIsMD = 1'b1; EXStart = 1'b1; EXIsDiv = 1'b1;
    #1;
    checks++;
    if (Stall !== 1'b1 || MDBusy !== 1'b0) begin
      errors++;
      $display("FAIL div_start: got stall=%b mdbusy=%b want 1 0", Stall, MDBusy);
    end
    tick();
    EXStart = 1'b0;
    bad = 0;
    for (int i = 1; i <= int'(DIV_CYC); i++) begin
      #1;
      if (MDBusy !== 1'b1 || Stall !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL div_busy_window: got %0d bad cycles want 0", bad);
    end
    #1;
    checks++;
    if (Stall !== 1'b0 || MDBusy !== 1'b0 || StallCnt !== 32'd11) begin
      errors++;
      $display("FAIL div_end: got stall=%b mdbusy=%b stallcnt=%0d want 0 0 11",
               Stall, MDBusy, StallCnt);
    end
  endtask

  task automatic test_mult_latency();
    apply_reset();
    EXStart = 1'b1;
    tick();
    EXStart = 1'b0;
    for (int i = 1; i <= int'(MULT_CYC) + 1; i++) begin
      #1;
      checks++;
      if (MDBusy !== (i <= int'(MULT_CYC))) begin
        errors++;
        $display("FAIL mult_latency[%0d]: got mdbusy=%b want %b", i, MDBusy,
                 i <= int'(MULT_CYC));
      end
      tick();
    end
  endtask

  task automatic test_flush();
    apply_reset();
    Req = 1'b1; EXStart = 1'b1; IDIsMD = 1'b1;
    EXRegDst = 5'd3; EXTnew = 2'd2; IDRs = 5'd3; IDUseRs = 1'b1; IDTuseRs = 2'd0;
    #1;
    checks++;
    if (Stall !== 1'b0 || IDEXClr !== 1'b1 || PCEn !== 1'b1) begin
      errors++;
      $display("FAIL flush: got stall=%b idexclr=%b pcen=%b want 0 1 1", Stall, IDEXClr, PCEn);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (MDBusy !== 1'b0 || StallCnt !== 32'd0) begin
      errors++;
      $display("FAIL flush_squash: got mdbusy=%b stallcnt=%0d want 0 0", MDBusy, StallCnt);
    end
  endtask

  task automatic test_reset_mid_mult();
    apply_reset();
    IDIsMD = 1'b1; EXStart = 1'b1;
    tick();
    EXStart = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; IDIsMD = 1'b0;
    #1;
    checks++;
    if (MDBusy !== 1'b0 || StallCnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_mult: got mdbusy=%b stallcnt=%0d want 0 0", MDBusy, StallCnt);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    EXRegDst = 5'd5; EXTnew = 2'd2; IDRs = 5'd5; IDUseRs = 1'b1; IDTuseRs = 2'd0;
    tick();
    #1;
    checks++;
    if (StallCnt !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL sat_reach: got %h want ffffffff", StallCnt);
    end
    tick();
    tick();
    #1;
    checks++;
    if (StallCnt !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL sat_hold: got %h want ffffffff", StallCnt);
    end
  endtask

  task automatic test_random();
    bit es;
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      reset     = ($urandom_range(0, 59) == 0);
      IDRs      = 5'($urandom_range(0, 3));
      IDRt      = 5'($urandom_range(0, 3));
      IDUseRs   = 1'($urandom);
      IDUseRt   = 1'($urandom);
      IDTuseRs  = 2'($urandom_range(0, 2));
      IDTuseRt  = 2'($urandom_range(0, 2));
      IDIsMD    = ($urandom_range(0, 3) == 0);
      EXRegDst  = 5'($urandom_range(0, 3));
      MEMRegDst = 5'($urandom_range(0, 3));
      EXTnew    = 2'($urandom_range(0, 2));
      MEMTnew   = 2'($urandom_range(0, 1));
      EXStart   = ($urandom_range(0, 7) == 0);
      EXIsDiv   = 1'($urandom);
      Req       = ($urandom_range(0, 9) == 0);
      #1;
      es = exp_stall();
      checks++;
      if (Stall !== es || PCEn !== !es || IFIDEn !== !es || IDEXClr !== (es || Req)) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: got stall=%b pcen=%b ifiden=%b idexclr=%b want stall=%b",
                 n, Stall, PCEn, IFIDEn, IDEXClr, es);
      end
      checks++;
      if (MDBusy !== m_busy() || StallCnt !== m_cnt) begin
        errors++;
        $display("FAIL rand_state[%0d]: got mdbusy=%b stallcnt=%0d want %b %0d",
                 n, MDBusy, StallCnt, m_busy(), m_cnt);
      end
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_zero_filter();
    test_divide();
    test_mult_latency();
    test_flush();
    test_reset_mid_mult();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 Parameters SHALL be: MULT_CYC, default 5, multiply busy cycles; DIV_CYC, default 10, divide busy cycles.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 IDRs, IDRt  input  5 each  source registers of the instruction in ID.
REQ-005 IDUseRs, IDUseRt  input  1 each  ID instruction reads rs / rt.
REQ-006 IDTuseRs, IDTuseRt  input  2 each  cycles from ID until the operand is consumed (0..2).
REQ-007 IDIsMD  input  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-008 EXRegDst, MEMRegDst  input  5 each  destination register of EX / MEM instruction (0 = none).
REQ-009 EXTnew, MEMTnew  input  2 each  cycles until the EX / MEM result is forwardable.
REQ-010 EXStart  input  1  EX instruction starts a mult/div this cycle.
REQ-011 EXIsDiv  input  1  qualifies EXStart: 1 = divide, 0 = multiply.
REQ-012 Req  input  1  exception/interrupt flush request.
REQ-013 Stall  output  1  freeze PC and IF/ID, bubble ID/EX.
REQ-014 PCEn, IFIDEn  output  1 each  both equal ~Stall.
REQ-015 IDEXClr  output  1  equals Stall | Req.
REQ-016 MDBusy  output  1  HI/LO unit busy.
REQ-017 StallCnt  output  32  total stall cycles since reset.

Function
REQ-018 RsHaz SHALL be IDUseRs & IDRs!=0 & ((IDRs==EXRegDst & EXTnew>IDTuseRs) | (IDRs==MEMRegDst & MEMTnew>IDTuseRs)).
REQ-019 RtHaz SHALL be the same with IDRt, IDUseRt, IDTuseRt.
REQ-020 Register 0 SHALL never cause a hazard, including when RegDst is 0.
REQ-021 MDHaz SHALL be IDIsMD & (EXStart | MDBusy).
REQ-022 Stall SHALL be combinational: (RsHaz | RtHaz | MDHaz) & ~Req.
REQ-023 The busy counter SHALL be 4 bits wide, with MDBusy = (count != 0).
REQ-024 Counter states: IDLE (count = 0) and BUSY (count > 0).
REQ-025 In IDLE, EXStart & ~Req SHALL load count with DIV_CYC if EXIsDiv, else MULT_CYC.
REQ-026 EXStart together with Req SHALL be ignored: the start is squashed.
REQ-027 In BUSY, count SHALL decrement by 1 per cycle and return to IDLE after reaching 0.
REQ-028 Req SHALL NOT abort a count already in progress.
REQ-029 EXStart while BUSY SHALL NOT occur, because MDHaz prevents it; if it does occur, it SHALL be ignored.
REQ-030 Latency: mult issued in EX at cycle T SHALL give MDBusy = 1 for cycles T+1 .. T+MULT_CYC and 0 at T+MULT_CYC+1.
REQ-031 StallCnt SHALL increment by 1 on every cycle with Stall = 1.
REQ-032 StallCnt SHALL saturate at 32'hFFFFFFFF, with no wrap.

Reset
REQ-033 When reset = 1 at a rising edge, count SHALL become 0 and StallCnt SHALL become 0.
REQ-034 The cycle after reset, MDBusy SHALL be 0.
REQ-035 Reset SHALL take priority over EXStart and over a count in progress (reset mid-divide returns to IDLE).
REQ-036 Outputs SHALL be purely combinational from state and inputs; with reset applied and all inputs 0, Stall = 0, PCEn = IFIDEn = 1 and IDEXClr = 0.

Verification
REQ-037 Load-use: EXRegDst=8, EXTnew=2, IDRs=8, IDUseRs=1, IDTuseRs=1 -> Stall=1, IDEXClr=1, PCEn=0; with EXTnew=1 -> Stall=0.
REQ-038 $0 filter: EXRegDst=0, IDRs=0, EXTnew=2, IDTuseRs=0 -> Stall=0.
REQ-039 Divide: EXStart=1, EXIsDiv=1 at cycle T, IDIsMD=1 held -> MDBusy=1 for T+1..T+10, Stall=1 for T..T+10, Stall=0 at T+11; StallCnt = 11.
REQ-040 Flush: Req=1 with EXStart=1 and a rs hazard -> Stall=0, IDEXClr=1, MDBusy stays 0 next cycle.
REQ-041 Reset mid-multiply: reset at T+2 of a mult -> MDBusy=0 and StallCnt=0 at T+3.
REQ-042 Saturation: StallCnt forced near max with 3 stall cycles from 32'hFFFFFFFE -> ends at 32'hFFFFFFFF.
